multi_pattern_seq_detector: RTL and testbench
=============================================

// Module: multi_pattern_seq_detector
// PURPOSE
//  Parametrised Mealy serial-pattern detector: compares a 1-bit input stream against NPAT
//  run-time programmable LEN-bit patterns, in block-aligned (framed) or sliding (overlapping) mode.
//  Sits after the serial front end; dec/dec_id feed control logic, match_cnt feeds status readout.
// PARAMETERS
//  LEN      4                      pattern length in bits (>=2)
//  NPAT     2                      number of pattern slots (>=1)
//  PAT_RST  {4'b0011,4'b1100}      reset patterns, slot p = PAT_RST[p*LEN +: LEN]; MSB = first bit received
//  CNT_W    8                      match counter width (MATCH_CNT_EN only)
//  (localparam ID_W = (NPAT>1) ? $clog2(NPAT) : 1)
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         synchronous reset, active-high
//  in_valid   in   1         in carries a stream bit this cycle
//  in         in   1         serial stream bit
//  cfg_we     in   1         config write strobe
//  cfg_idx    in   ID_W      pattern slot written by cfg_we
//  cfg_pat    in   LEN       pattern value for slot cfg_idx
//  cfg_en     in   1         enable for slot cfg_idx
//  cfg_mode   in   1         0 = block-aligned, 1 = sliding; written on every cfg_we
//  dec        out  1         Mealy match, combinational from state + in_valid/in
//  dec_id     out  ID_W      lowest matching enabled slot; 0 when dec=0
//  match_cnt  out  CNT_W     saturating match count (MATCH_CNT_EN only)
// BEHAVIOUR
//  - State: hist[LEN-2:0] (last LEN-1 valid bits, newest at bit 0), pos (0..LEN-1), fill
//    (0..LEN-1, saturating), pat[NPAT], pat_en[NPAT], mode.
//  - Reset: hist=0, pos=0, fill=0, pat=PAT_RST, pat_en=all 1, mode=0, match_cnt=0.
//    Outputs: dec=0 and dec_id=0 while rst=1, regardless of in.
//  - Candidate word w = {hist, in}. Slot p hits when pat_en[p] && w==pat[p].
//  - Block mode: dec = in_valid && pos==LEN-1 && any hit. Every valid bit advances pos;
//    pos wraps LEN-1 -> 0 whether or not a hit occurs, so frames are strictly non-overlapping.
//  - Sliding mode: dec = in_valid && fill==LEN-1 && any hit. After a hit the history is kept,
//    so overlapping matches are detected (pattern 1111 on 11111 -> dec on bits 4 and 5).
//  - in_valid=0: no state change, dec=0 (stall, no frame/history loss).
//  - Latency: dec asserted in the same cycle as the last pattern bit (zero-cycle Mealy);
//    consumers sample it on the following clk edge.
//  - Multiple hits in one cycle: dec=1, dec_id = lowest index.
//  - cfg_we: at the next edge pat[cfg_idx]<=cfg_pat, pat_en[cfg_idx]<=cfg_en, mode<=cfg_mode;
//    hist, pos and fill cleared. cfg_we has priority: an in_valid bit in the same cycle is
//    dropped and dec is forced 0 in that cycle. cfg_idx >= NPAT: pattern ignored, flush and
//    mode still applied.
//  - rst mid-frame: partial frame discarded, next valid bit is position 0.
//  - All-enables-cleared: dec never asserts; pos/fill still advance.
// CONFIGURATION
//  - MATCH_CNT_EN defined: match_cnt increments by 1 on every edge where dec=1, saturates at
//    2**CNT_W-1, cleared by rst only (not by cfg_we).
//  - MATCH_CNT_EN undefined: counter not built; match_cnt port present, tied to 0.
// TESTING
//  1 reset defaults, block mode: stream 1100 0011 -> dec=1 on bit 4 (id 0) and bit 8 (id 1), else 0.
//  2 misaligned block: stream 0 1100 000 -> no dec (frames 0110, 0000); the following 1100 -> dec, id 0.
//  3 sliding: cfg_we idx0 pat 1010 en1 mode1, idx1 en0; stream 101010 -> dec on bits 4 and 6, id 0.
//  4 stall/priority: 1,1,0 then in_valid=0 for 3 cycles, then 0 -> dec on resume bit;
//    cfg_we concurrent with final bit -> dec=0 and history cleared.
//  5 overlap + tie: slots 0 and 1 both 1100 -> dec_id=0; disable slot 0 -> dec_id=1.
//  6 MATCH_CNT_EN, CNT_W=2: five matches -> match_cnt 1,2,3,3,3; rst -> 0; dec=0 during rst.

Source files
------------

// File: rtl/multi_pattern_seq_detector.sv
// ============================================================================
// multi_pattern_seq_detector
// ----------------------------------------------------------------------------
// Purpose
//   Mealy serial-pattern detector. A 1-bit input stream is compared against
//   NPAT patterns of LEN bits each, and the patterns can be changed at run
//   time. There are two operating modes:
//     - block-aligned: the stream is split into back-to-back LEN-bit frames.
//       A match is reported only on the last bit of a frame.
//     - sliding: every valid bit ends a candidate word once LEN bits have
//       been seen, so overlapping matches are all reported.
//   The detector sits after the serial front end. dec/dec_id drive control
//   logic and match_cnt drives status readout.
//
// Parameters
//   LEN      pattern length in bits (>= 2)
//   NPAT     number of pattern slots (>= 1)
//   PAT_RST  reset patterns: slot p = PAT_RST[p*LEN +: LEN], MSB = first bit
//   CNT_W    match counter width
//
// Ports
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      'in' carries a stream bit this cycle
//   in         in   1      serial stream bit
//   cfg_we     in   1      config write strobe (takes priority over in_valid)
//   cfg_idx    in   ID_W   pattern slot written by cfg_we
//   cfg_pat    in   LEN    pattern value for slot cfg_idx
//   cfg_en     in   1      enable for slot cfg_idx
//   cfg_mode   in   1      0 = block-aligned, 1 = sliding
//   dec        out  1      match, combinational from state and in_valid/in
//   dec_id     out  ID_W   lowest matching enabled slot, 0 when dec = 0
//   match_cnt  out  CNT_W  saturating match count
//
// Configuration macro
//   MATCH_CNT_EN  When defined, a saturating match counter is built. It is
//                 cleared only by rst. When undefined, match_cnt is tied to 0.
// ============================================================================
module multi_pattern_seq_detector #(
    parameter int                   LEN     = 4,
    parameter int                   NPAT    = 2,
    parameter logic [NPAT*LEN-1:0]  PAT_RST = {4'b0011, 4'b1100},
    parameter int                   CNT_W   = 8,
    localparam int                  ID_W    = (NPAT > 1) ? $clog2(NPAT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_we,
    input  logic [ID_W-1:0]  cfg_idx,
    input  logic [LEN-1:0]   cfg_pat,
    input  logic             cfg_en,
    input  logic             cfg_mode,
    output logic             dec,
    output logic [ID_W-1:0]  dec_id,
    output logic [CNT_W-1:0] match_cnt
);

    // pos and fill both count 0..LEN-1. LEN >= 2, so PW is at least 1.
    localparam int             PW   = $clog2(LEN);
    localparam logic [PW-1:0]  LAST = PW'(LEN - 1);

    typedef enum logic {
        MODE_BLOCK = 1'b0,
        MODE_SLIDE = 1'b1
    } mode_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [LEN-2:0]            hist_q,   hist_d;    // last LEN-1 bits, newest at bit 0
    logic [PW-1:0]             pos_q,    pos_d;     // bit position inside the current frame
    logic [PW-1:0]             fill_q,   fill_d;    // saturating count of bits held in hist
    logic [NPAT-1:0][LEN-1:0]  pat_q,    pat_d;
    logic [NPAT-1:0]           pat_en_q, pat_en_d;
    mode_e                     mode_q,   mode_d;

    // ------------------------------------------------------------------------
    // Match logic
    // ------------------------------------------------------------------------
    logic [LEN-1:0]  word;        // candidate word: history followed by the current bit
    logic [NPAT-1:0] hit;
    logic [ID_W-1:0] hit_id;
    logic            word_ready;  // the current bit completes a frame or window

    assign word = {hist_q, in};

    always_comb begin
        // NOTE: every signal written in an always_comb gets a default value
        // first. Without one, a path that skips the write infers a latch.
        hit    = '0;
        hit_id = '0;
        for (int p = 0; p < NPAT; p++) begin
            hit[p] = pat_en_q[p] && (word == pat_q[p]);
        end
        // Scan from the highest slot down so the lowest matching index is
        // written last and wins.
        for (int p = NPAT - 1; p >= 0; p--) begin
            if (hit[p]) begin
                hit_id = ID_W'(p);
            end
        end
    end

    assign word_ready = (mode_q == MODE_SLIDE) ? (fill_q == LAST) : (pos_q == LAST);

    // A config write drops a concurrent stream bit, so it also blocks dec.
    // rst blocks dec directly, because the state registers still hold
    // pre-reset values during the reset cycle.
    assign dec    = !rst && in_valid && !cfg_we && word_ready && (|hit);
    assign dec_id = dec ? hit_id : '0;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        hist_d   = hist_q;
        pos_d    = pos_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        pat_en_d = pat_en_q;
        mode_d   = mode_q;

        if (cfg_we) begin
            // Reconfiguring always restarts framing and history. A slot index
            // outside the table changes no pattern, but the flush and the mode
            // change still take effect.
            hist_d = '0;
            pos_d  = '0;
            fill_d = '0;
            mode_d = mode_e'(cfg_mode);
            for (int p = 0; p < NPAT; p++) begin
                if (cfg_idx == ID_W'(p)) begin
                    pat_d[p]    = cfg_pat;
                    pat_en_d[p] = cfg_en;
                end
            end
        end else if (in_valid) begin
            // The lower LEN-1 bits of the candidate word become the new history.
            hist_d = word[LEN-2:0];
            // pos wraps on every frame end, with or without a hit, so frames
            // never overlap in block mode.
            pos_d  = (pos_q == LAST) ? '0 : pos_q + PW'(1);
            fill_d = (fill_q == LAST) ? fill_q : fill_q + PW'(1);
        end
        // With in_valid = 0 the stream is stalled and all state holds.
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking
        // assignments. Every register then samples pre-edge values, whatever
        // order the statements appear in.
        if (rst) begin
            hist_q   <= '0;
            pos_q    <= '0;
            fill_q   <= '0;
            // NOTE: the pattern table is small and its power-up contents are
            // part of its function, so it is reset like the control state.
            // A large storage array would normally be left unreset.
            pat_q    <= PAT_RST;
            pat_en_q <= '1;
            mode_q   <= MODE_BLOCK;
        end else begin
            hist_q   <= hist_d;
            pos_q    <= pos_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            pat_en_q <= pat_en_d;
            mode_q   <= mode_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional match counter
    // ------------------------------------------------------------------------
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // cfg_we does not clear the counter; only rst does.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (dec && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_pattern_seq_detector.sv
// ============================================================================
// tb_multi_pattern_seq_detector
// ----------------------------------------------------------------------------
// Scoreboard bench for multi_pattern_seq_detector (LEN=4, NPAT=2, default
// reset patterns). Each driven bit pushes its expected {dec, dec_id} onto a
// queue. That entry is popped and compared on the falling edge of the same
// cycle, because the detector is zero-latency Mealy. With MATCH_CNT_EN
// defined, the counter is built with CNT_W=2 to exercise saturation.
// ============================================================================
`timescale 1ns/1ps
module tb_multi_pattern_seq_detector;

    localparam int LEN  = 4;
    localparam int NPAT = 2;
    localparam int ID_W = 1;
`ifdef MATCH_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             cfg_we;
    logic [ID_W-1:0]  cfg_idx;
    logic [LEN-1:0]   cfg_pat;
    logic             cfg_en;
    logic             cfg_mode;
    logic             dec;
    logic [ID_W-1:0]  dec_id;
    logic [CNT_W-1:0] match_cnt;

    always #5 clk = ~clk;

    multi_pattern_seq_detector #(
        .LEN     (LEN),
        .NPAT    (NPAT),
        .PAT_RST ({4'b0011, 4'b1100}),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_bit),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_pat   (cfg_pat),
        .cfg_en    (cfg_en),
        .cfg_mode  (cfg_mode),
        .dec       (dec),
        .dec_id    (dec_id),
        .match_cnt (match_cnt)
    );

    typedef struct packed {
        logic            dec;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    string cur   = "init";

    // Drives one cycle of stimulus and pushes the expected output. It then
    // pops and compares that output on the falling edge, and returns 1 ns
    // after the next rising edge.
    task automatic drive_bit(input logic v, input logic b, input logic ed, input int eid);
        exp_t e;
        exp_t got;
        in_valid = v;
        in_bit   = b;
        e.dec    = ed;
        e.id     = ed ? ID_W'(eid) : '0;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        total++;
        if (dec !== got.dec || dec_id !== got.id) begin
            bad++;
            $display("FAIL %s dec/dec_id: got %b/%0d want %b/%0d", cur, dec, dec_id, got.dec, got.id);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends n valid bits, first bit at bits[n-1]. exp_mask marks, with the same
    // bit ordering, the bits on which dec is expected (all with id eid).
    task automatic send_stream(input logic [15:0] bits, input int n,
                               input logic [15:0] exp_mask, input int eid);
        for (int i = 0; i < n; i++) begin
            drive_bit(1'b1, bits[n-1-i], exp_mask[n-1-i], eid);
        end
    endtask

    // Applies one config write. A stream bit (v, b) can be presented in the
    // same cycle; it must be dropped and dec must stay low.
    task automatic do_cfg(input int idx, input logic [LEN-1:0] pat, input logic en,
                          input logic mode, input logic v, input logic b);
        cfg_we   = 1'b1;
        cfg_idx  = ID_W'(idx);
        cfg_pat  = pat;
        cfg_en   = en;
        cfg_mode = mode;
        drive_bit(v, b, 1'b0, 0);
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        cur = "reset";
        rst = 1'b1;
        drive_bit(1'b1, 1'b1, 1'b0, 0);
        drive_bit(1'b1, 1'b0, 1'b0, 0);
        drive_bit(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        total++;
        if (match_cnt !== '0) begin
            bad++;
            $display("FAIL reset match_cnt: got %0d want 0", match_cnt);
        end
    endtask

    task automatic test_block_default();
        cur = "block_default";
        send_stream(16'b1100, 4, 16'b0001, 0);
        send_stream(16'b0011, 4, 16'b0001, 1);
    endtask

    task automatic test_misaligned();
        cur = "misaligned";
        send_stream(16'b0110_0000, 8, 16'b0, 0);
        send_stream(16'b1100, 4, 16'b0001, 0);
    endtask

    task automatic test_sliding();
        cur = "sliding";
        do_cfg(0, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
        do_cfg(1, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0);
        send_stream(16'b101010, 6, 16'b000101, 0);
        cur = "sliding_overlap";
        do_cfg(1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        send_stream(16'b11111, 5, 16'b00011, 1);
    endtask

    task automatic test_stall_priority();
        // Reset in the middle of a frame drops the partial frame.
        cur = "rst_mid_frame";
        rst = 1'b1;
        drive_bit(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        send_stream(16'b11, 2, 16'b0, 0);
        rst = 1'b1;
        drive_bit(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        send_stream(16'b1100, 4, 16'b0001, 0);

        cur = "stall";
        send_stream(16'b110, 3, 16'b0, 0);
        drive_bit(1'b0, 1'b0, 1'b0, 0);
        drive_bit(1'b0, 1'b1, 1'b0, 0);
        drive_bit(1'b0, 1'b0, 1'b0, 0);
        drive_bit(1'b1, 1'b0, 1'b1, 0);

        cur = "cfg_priority";
        send_stream(16'b110, 3, 16'b0, 0);
        do_cfg(0, 4'b1100, 1'b1, 1'b0, 1'b1, 1'b0);
        // If the flush failed, the first 0 here would complete 1100.
        send_stream(16'b0011, 4, 16'b0001, 1);
    endtask

    task automatic test_tie();
        cur = "tie_both";
        do_cfg(0, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
        do_cfg(1, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
        send_stream(16'b1100, 4, 16'b0001, 0);
        cur = "tie_slot0_off";
        do_cfg(0, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
        send_stream(16'b1100, 4, 16'b0001, 1);
        cur = "all_disabled_block";
        do_cfg(1, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
        send_stream(16'b1100_0011_1100, 12, 16'b0, 0);
        cur = "all_disabled_slide";
        do_cfg(1, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0);
        send_stream(16'b1100_1100, 8, 16'b0, 0);
    endtask

    task automatic test_counter();
        int exp_cnt [5];
        exp_cnt = '{1, 2, 3, 3, 3};
        cur = "counter";
        rst = 1'b1;
        drive_bit(1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_stream(16'b1100, 4, 16'b0001, 0);
            total++;
`ifdef MATCH_CNT_EN
            if (match_cnt !== CNT_W'(exp_cnt[i])) begin
                bad++;
                $display("FAIL counter match %0d: got %0d want %0d", i, match_cnt, exp_cnt[i]);
            end
`else
            if (match_cnt !== '0) begin
                bad++;
                $display("FAIL counter tied %0d: got %0d want 0", i, match_cnt);
            end
`endif
        end
        // A config write must leave the count alone.
        do_cfg(0, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
`ifdef MATCH_CNT_EN
        if (match_cnt !== CNT_W'(3)) begin
            bad++;
            $display("FAIL counter after cfg: got %0d want 3", match_cnt);
        end
`else
        if (match_cnt !== '0) begin
            bad++;
            $display("FAIL counter after cfg: got %0d want 0", match_cnt);
        end
`endif
        // The 4th bit would complete 1100, but rst is high so dec must stay 0.
        cur = "dec_during_rst";
        send_stream(16'b110, 3, 16'b0, 0);
        rst = 1'b1;
        drive_bit(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        total++;
        if (match_cnt !== '0) begin
            bad++;
            $display("FAIL counter after rst: got %0d want 0", match_cnt);
        end
        send_stream(16'b1100, 4, 16'b0001, 0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_pat  = '0;
        cfg_en   = 1'b0;
        cfg_mode = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_block_default();
        test_misaligned();
        test_sliding();
        test_stall_priority();
        test_tie();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
